// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states and
// the iteration mode selector used by the datapath step.
package mul_div_unit_pkg;

  localparam logic [1:0] MULDIV_MULTU = 2'b00;
  localparam logic [1:0] MULDIV_DIVU  = 2'b01;
  localparam logic [1:0] MULDIV_MULT  = 2'b10;
  localparam logic [1:0] MULDIV_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MULDIV_IDLE   = 2'd0,
    MULDIV_RUN    = 2'd1,
    MULDIV_FINISH = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-side bus of the multiply/divide unit: request, HI/LO moves and results.
interface mul_div_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] inA;
  logic [N-1:0] inB;
  logic         write_hi;
  logic         write_lo;
  logic [N-1:0] write_data;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         div_by_zero;

  modport master (
    output start, op, inA, inB, write_hi, write_lo, write_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, inA, inB, write_hi, write_lo, write_data,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_step.sv
// One combinational iteration: shift-add multiply on {carry, P, multiplier}
// or restoring divide on {remainder, quotient}.
module mul_div_step
  import mul_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  step_mode_t   mode,
  input  logic [2*N:0] acc,
  input  logic [N-1:0] operand,
  output logic [2*N:0] acc_next
);
  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] trial;

  always_comb begin
    sum      = acc[2*N:N] + (acc[0] ? {1'b0, operand} : '0);
    shifted  = acc[2*N-1:N-1];
    // Trial sign bit is reliable: remainder*2+bit is always below 2*divisor.
    trial    = shifted - {1'b0, operand};
    acc_next = '0;
    if (mode == STEP_MUL)
      acc_next = {1'b0, sum, acc[N-1:1]};
    else if (trial[N])
      acc_next = {1'b0, shifted[N-1:0], acc[N-2:0], 1'b0};
    else
      acc_next = {1'b0, trial[N-1:0], acc[N-2:0], 1'b1};
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO registers, N+1 cycle latency.
// Signed operation is built only when MULDIV_SIGNED_EN is defined.
module mul_div_unit #(
  parameter int N = 32
) (
  input logic           clock,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  import mul_div_unit_pkg::*;

  localparam int CW = $clog2(N);

  muldiv_state_t state, state_next;
  logic [CW-1:0] count;
  logic [2*N:0]  acc, acc_next;
  logic [N-1:0]  operand, a_mag, b_mag;
  logic [N-1:0]  hi_reg, lo_reg, hi_res, lo_res;
  step_mode_t    mode;
  logic          accept, iterate, finish, reg_write;
  logic          div_zero, dz_reg, done_reg;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*N-1:0] cond_neg_wide(input logic [2*N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign a_neg = bus.op[1] & bus.inA[N-1];
  assign b_neg = bus.op[1] & bus.inB[N-1];
  assign a_mag = a_neg ? -bus.inA : bus.inA;
  assign b_mag = b_neg ? -bus.inB : bus.inB;

  always_ff @(posedge clock) begin
    if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_sign_sel;
  assign unused_sign_sel = bus.op[1];
  assign a_mag = bus.inA;
  assign b_mag = bus.inB;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= MULDIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MULDIV_IDLE:   if (bus.start) state_next = MULDIV_RUN;
      MULDIV_RUN:    if (count == '0) state_next = MULDIV_FINISH;
      MULDIV_FINISH: state_next = MULDIV_IDLE;
      default:       state_next = MULDIV_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    reg_write = 1'b0;
    case (state)
      MULDIV_IDLE: begin
        accept    = bus.start;
        reg_write = 1'b1;
      end
      MULDIV_RUN:    iterate = 1'b1;
      MULDIV_FINISH: finish  = 1'b1;
      default: ;
    endcase
    bus.busy = (state != MULDIV_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (accept)
      count <= CW'(N-1);
    else if (iterate && count != '0)
      count <= count - 1'b1;
  end

  // Divide keeps the dividend in the quotient half; multiply keeps the multiplier there.
  always_ff @(posedge clock) begin
    if (accept) begin
      mode <= step_mode_t'(bus.op[0]);
      if (bus.op[0]) begin
        acc     <= {1'b0, {N{1'b0}}, a_mag};
        operand <= b_mag;
      end else begin
        acc     <= {1'b0, {N{1'b0}}, b_mag};
        operand <= a_mag;
      end
    end else if (iterate) begin
      acc <= acc_next;
    end
  end

  mul_div_step #(.N(N)) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  assign div_zero = (mode == STEP_DIV) && (operand == '0);

  always_comb begin
    hi_res = acc[2*N-1:N];
    lo_res = acc[N-1:0];
`ifdef MULDIV_SIGNED_EN
    if (mode == STEP_MUL) begin
      {hi_res, lo_res} = cond_neg_wide(acc[2*N-1:0], neg_q);
    end else begin
      hi_res = cond_neg(acc[2*N-1:N], neg_r);
      lo_res = cond_neg(acc[N-1:0], neg_q);
    end
`endif
    // A zero divisor leaves the dividend in the remainder; the quotient is forced.
    if (div_zero) lo_res = '1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      dz_reg   <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (accept) dz_reg <= 1'b0;
      if (reg_write && bus.write_hi) hi_reg <= bus.write_data;
      if (reg_write && bus.write_lo) lo_reg <= bus.write_data;
      if (finish) begin
        hi_reg <= hi_res;
        lo_reg <= lo_res;
        dz_reg <= div_zero;
      end
    end
  end

  assign bus.done        = done_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.div_by_zero = dz_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO/flag/done
// cycle; a negedge monitor pops and compares whenever done is high.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];

  mul_div_unit_if #(.N(32)) bus ();

  mul_div_unit #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, bus.hi, e.hi);
        check({e.name, "_lo"}, bus.lo, e.lo);
        check({e.name, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dz});
        check({e.name, "_latency"}, cyc, e.done_cyc);
      end
    end
  end

  // inject > 0 pulses start (multu 2*3) and write_hi 0xAA that many cycles into RUN.
  task automatic run_op(input string name, input logic [1:0] op_v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int inject);
    exp_t e;
    int   n;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.inA   = a;
    bus.inB   = b;
    @(posedge clock);
    #1;
    bus.start  = 1'b0;
    e.name     = name;
    e.hi       = ehi;
    e.lo       = elo;
    e.dz       = edz;
    e.done_cyc = cyc + 33;
    sb.push_back(e);
    check({name, "_dz_cleared"}, {31'd0, bus.div_by_zero}, 32'd0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (inject != 0 && i == inject) begin
        bus.start      = 1'b1;
        bus.op         = MULDIV_MULTU;
        bus.inA        = 32'd2;
        bus.inB        = 32'd3;
        bus.write_hi   = 1'b1;
        bus.write_data = 32'hAA;
      end else if (inject != 0 && i == inject + 1) begin
        bus.start    = 1'b0;
        bus.write_hi = 1'b0;
      end
      if (bus.busy === 1'b1) n++;
      else break;
    end
    check({name, "_busy_cycles"}, n, 32'd33);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.inA        = '0;
    bus.inB        = '0;
    bus.write_hi   = 1'b0;
    bus.write_lo   = 1'b0;
    bus.write_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("multu_max", MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    run_op("divu_100_7", MULDIV_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    run_op("divu_by_zero", MULDIV_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_m3_5", MULDIV_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
    run_op("div_m7_2", MULDIV_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div_minneg_m1", MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 0);
`else
    run_op("mult_m3_5", MULDIV_MULT, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0, 0);
    run_op("div_m7_2", MULDIV_DIV, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 0);
    run_op("div_minneg_m1", MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 0);
`endif
    run_op("div_neg_by_zero", MULDIV_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0);
    run_op("multu_busy_inject", MULDIV_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 5);

    // Register moves in IDLE.
    @(negedge clock);
    bus.write_hi   = 1'b1;
    bus.write_lo   = 1'b1;
    bus.write_data = 32'h11;
    @(negedge clock);
    bus.write_hi   = 1'b0;
    bus.write_data = 32'h22;
    @(posedge clock);
    #1;
    check("mthi_mtlo_hi", bus.hi, 32'h11);
    check("mthi_mtlo_lo", bus.lo, 32'h22);
    @(negedge clock);
    bus.write_lo   = 1'b1;
    bus.write_data = 32'h55;
    @(posedge clock);
    #1;
    bus.write_lo = 1'b0;
    check("mtlo_lo", bus.lo, 32'h55);
    check("mtlo_hi_kept", bus.hi, 32'h11);

    // Reset in the middle of RUN.
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = MULDIV_MULTU;
    bus.inA   = 32'hFFFFFFFF;
    bus.inB   = 32'd2;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_hi", bus.hi, 32'd0);
    check("midreset_lo", bus.lo, 32'd0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    check("midreset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("divu_9_3", MULDIV_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 0);

    repeat (40) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
